// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and RV32I encoding constants for the multi-cycle CPU.
package cpu_pkg;
    localparam int WORD     = 32;
    localparam int REG_SIZE = 5;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_MUL} alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational XLEN-wide ALU; SLT is signed, all results wrap.
module mc_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y
);
    always_comb begin
        y = op == ALU_ADD ? a + b :
            op == ALU_SUB ? a - b :
            op == ALU_AND ? a & b :
            op == ALU_OR  ? a | b :
            op == ALU_XOR ? a ^ b :
            op == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
                            a * b;
    end
endmodule

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle RV32I subset CPU (FETCH/DECODE/EXEC/MEM/WB/HALT).
// MC_CPU_MUL_EN enables the MUL instruction; otherwise MUL decodes as illegal.
module mc_cpu
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [WORD-1:0]   imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [XLEN-1:0]   pc,
    output logic              retire,
    output logic              halted
);
`ifdef MC_CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    alu_op_e             op_q, op_d, dec_op;
    logic [XLEN-1:0]     pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic [WORD-1:0]     ir_q, ir_d;
    logic [XLEN-1:0]     rf_q [NREGS];
    logic [XLEN-1:0]     imm, alu_y, rd_a, rd_b;
    logic [REG_SIZE-1:0] rd, rs1, rs2;
    logic [6:0]          opcode, f7;
    logic [2:0]          f3;
    logic                is_r, is_addi, is_lw, is_sw, is_beq, r_base, r_sub, r_mul;
    logic                legal, rd_bad, wb_en;

    always_comb begin
        opcode  = ir_q[6:0];
        rd      = ir_q[11:7];
        f3      = ir_q[14:12];
        rs1     = ir_q[19:15];
        rs2     = ir_q[24:20];
        f7      = ir_q[31:25];
        is_r    = opcode == OP_R;
        is_addi = opcode == OP_IMM;
        is_lw   = opcode == OP_LOAD;
        is_sw   = opcode == OP_STORE;
        is_beq  = opcode == OP_BRANCH;
        r_base  = f7 == F7_BASE && (f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND});
        r_sub   = f7 == F7_SUB && f3 == F3_ADD;
        r_mul   = f7 == F7_MUL && f3 == F3_ADD;
        legal   = (is_r && (r_base || r_sub || (MUL_EN && r_mul))) || (is_addi && f3 == F3_ADD) ||
                  ((is_lw || is_sw) && f3 == F3_W) || (is_beq && f3 == F3_BEQ);
        rd_bad  = (is_r || is_addi || is_lw) && int'(rd) >= NREGS;
        dec_op  = !is_r        ? ALU_ADD :
                  r_sub        ? ALU_SUB :
                  r_mul        ? ALU_MUL :
                  f3 == F3_SLT ? ALU_SLT :
                  f3 == F3_XOR ? ALU_XOR :
                  f3 == F3_OR  ? ALU_OR  :
                  f3 == F3_AND ? ALU_AND : ALU_ADD;
        imm     = is_sw  ? {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]} :
                  is_beq ? {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0} :
                           {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        rd_a    = int'(rs1) < NREGS ? rf_q[rs1] : '0;
        rd_b    = int'(rs2) < NREGS ? rf_q[rs2] : '0;
    end

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (is_r ? b_q : imm_q),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            op_q    <= ALU_ADD;
            res_q   <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            op_q    <= op_d;
            res_q   <= res_d;
            if (wb_en) rf_q[rd] <= res_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        op_d    = op_q;
        res_d   = res_q;
        wb_en   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = imem_ready ? imem_rdata : ir_q;
                state_d = imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                a_d     = rd_a;
                b_d     = rd_b;
                imm_d   = imm;
                op_d    = dec_op;
                state_d = legal && !rd_bad ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                res_d   = alu_y;
                pc_d    = !is_beq ? pc_q : a_q == b_q ? pc_q + imm_q : pc_q + XLEN'(4);
                state_d = is_beq ? S_FETCH : is_lw || is_sw ? S_MEM : S_WB;
            end
            S_MEM: begin
                res_d   = dmem_ready && is_lw ? dmem_rdata : res_q;
                pc_d    = dmem_ready && is_sw ? pc_q + XLEN'(4) : pc_q;
                state_d = !dmem_ready ? S_MEM : is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                wb_en   = rd != '0;
                pc_d    = pc_q + XLEN'(4);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Requests are gated by rst_n so they drop the moment reset asserts.
    always_comb begin
        imem_req   = rst_n && state_q == S_FETCH;
        imem_addr  = pc_q;
        dmem_req   = rst_n && state_q == S_MEM;
        dmem_we    = state_q == S_MEM && is_sw;
        dmem_addr  = res_q;
        dmem_wdata = b_q;
        pc         = pc_q;
        halted     = state_q == S_HALT;
        retire     = state_q == S_WB || (state_q == S_EXEC && is_beq) ||
                     (state_q == S_MEM && is_sw && dmem_ready);
    end
endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed self-checking bench for mc_cpu with simple imem/dmem models.
module tb_mc_cpu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic        imem_stall = 1'b0;
    int          dmem_lat = 0, dcnt = 0, retire_cnt = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mc_cpu dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .halted(halted)
    );

    assign imem_ready = !imem_stall;
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_ready = dmem_req && dcnt >= dmem_lat;
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        dcnt <= dmem_req && !dmem_ready ? dcnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) retire_cnt <= 0;
        else if (retire) retire_cnt <= retire_cnt + 1;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1, input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [11:0] m = 12'(imm);
        return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] beq(input int rs1, input int rs2, input int imm);
        logic [12:0] m = 13'(imm);
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'b000, m[4:1], m[11], 7'h63};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset, clears memories; program words are loaded before release().
    task automatic begin_prog();
        @(negedge clk);
        rst_n = 1'b0;
        imem_stall = 1'b0;
        dmem_lat = 0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'hFFFF_FFFF;
            dmem[i] = 32'h0;
        end
    endtask

    task automatic release_rst();
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic run_until_pc(input logic [31:0] target, input int budget, input string nm);
        int n = 0;
        while (!(pc == target && imem_req) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout, pc=%h required %h", nm, pc, target);
        end
    endtask

    task automatic test_reset();
        begin_prog();
        step(1);
        checks++;
        if ({pc, imem_req, dmem_req, retire, halted} !== {32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h req=%b%b retire=%b halted=%b required pc=0 all zero", pc, imem_req, dmem_req, retire, halted);
        end
    endtask

    task automatic test_alu_seq();
        begin_prog();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, -3);
        imem[2] = r_t(7'h00, 2, 1, 3'b000, 3);
        release_rst();
        step(11);
        checks++;
        if (pc !== 32'h8) begin errors++; $display("FAIL alu_seq_pc11: got %h required 00000008", pc); end
        step(1);
        checks++;
        if (pc !== 32'hC || !imem_req) begin errors++; $display("FAIL alu_seq_pc12: got %h req=%b required 0000000c req=1", pc, imem_req); end
        checks++;
        if (retire_cnt !== 3) begin errors++; $display("FAIL alu_seq_retire: got %0d required 3", retire_cnt); end
        checks++;
        if (dut.rf_q[3] !== 32'h2) begin errors++; $display("FAIL alu_seq_x3: got %h required 00000002", dut.rf_q[3]); end
        checks++;
        if (dut.rf_q[2] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL alu_seq_x2: got %h required fffffffd", dut.rf_q[2]); end
    endtask

    task automatic test_mem_wait();
        begin_prog();
        imem[0] = addi(1, 0, 5);
        imem[1] = sw(1, 0, 8);
        imem[2] = lw(4, 0, 8);
        release_rst();
        dmem_lat = 3;
        run_until_pc(32'h4, 20, "mem_sw_fetch");
        step(3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ready} !== {3'b011, 32'h8, 32'h5, k == 3}) begin
                errors++;
                $display("FAIL sw_hold_%0d: req=%b%b we=%b addr=%h wdata=%h rdy=%b required 01 1 00000008 00000005 %b",
                         k, imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ready, k == 3);
            end
            step(1);
        end
        checks++;
        if (dmem[2] !== 32'h5 || pc !== 32'h8) begin errors++; $display("FAIL sw_done: mem=%h pc=%h required 00000005 00000008", dmem[2], pc); end
        step(3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h8}) begin
                errors++;
                $display("FAIL lw_hold_%0d: req=%b we=%b addr=%h required 1 0 00000008", k, dmem_req, dmem_we, dmem_addr);
            end
            step(1);
        end
        run_until_pc(32'hC, 5, "lw_done");
        checks++;
        if (dut.rf_q[4] !== 32'h5) begin errors++; $display("FAIL lw_x4: got %h required 00000005", dut.rf_q[4]); end
    endtask

    task automatic test_mem_zero_wait();
        begin_prog();
        imem[0] = addi(1, 0, 5);
        imem[1] = sw(1, 0, 8);
        imem[2] = lw(4, 0, 8);
        release_rst();
        step(12);
        checks++;
        if (pc !== 32'h8) begin errors++; $display("FAIL zw_pc12: got %h required 00000008", pc); end
        step(1);
        checks++;
        if (pc !== 32'hC || dut.rf_q[4] !== 32'h5) begin errors++; $display("FAIL zw_pc13: pc=%h x4=%h required 0000000c 00000005", pc, dut.rf_q[4]); end
    endtask

    task automatic test_beq(input bit taken);
        begin_prog();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, -3);
        for (int i = 2; i < 8; i++) imem[i] = addi(0, 0, 0);
        imem[8]  = taken ? beq(1, 1, 16) : beq(1, 2, 16);
        imem[9]  = addi(7, 0, 2);
        imem[12] = addi(7, 0, 1);
        release_rst();
        run_until_pc(32'h20, 60, "beq_reach");
        run_until_pc(taken ? 32'h30 : 32'h24, 6, "beq_target");
        checks++;
        if (imem_addr !== (taken ? 32'h30 : 32'h24)) begin
            errors++;
            $display("FAIL beq_addr_%0d: got %h required %h", taken, imem_addr, taken ? 32'h30 : 32'h24);
        end
        step(4);
        checks++;
        if (dut.rf_q[7] !== (taken ? 32'h1 : 32'h2)) begin errors++; $display("FAIL beq_path_%0d: x7=%h", taken, dut.rf_q[7]); end
    endtask

    task automatic test_ops();
        logic [31:0] exp [11] = '{0, 5, 32'hFFFF_FFFD, 0, 0, 1, 8, 5, 32'hFFFF_FFFD, 32'hFFFF_FFF8, 0};
        begin_prog();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, -3);
        imem[2] = addi(0, 0, 7);
        imem[3] = r_t(7'h00, 1, 2, 3'b010, 5);
        imem[4] = r_t(7'h20, 2, 1, 3'b000, 6);
        imem[5] = r_t(7'h00, 2, 1, 3'b111, 7);
        imem[6] = r_t(7'h00, 2, 1, 3'b110, 8);
        imem[7] = r_t(7'h00, 2, 1, 3'b100, 9);
        imem[8] = r_t(7'h00, 2, 1, 3'b010, 10);
        release_rst();
        run_until_pc(32'h24, 60, "ops_run");
        for (int r = 0; r < 11; r++) begin
            if (r == 3 || r == 4) continue;
            checks++;
            if (dut.rf_q[r] !== exp[r]) begin errors++; $display("FAIL ops_x%0d: got %h required %h", r, dut.rf_q[r], exp[r]); end
        end
    endtask

    task automatic test_halt();
        begin_prog();
        release_rst();
        step(1);
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b required 0", halted); end
        step(1);
        checks++;
        if ({halted, imem_req, dmem_req} !== 3'b100) begin errors++; $display("FAIL halt_enter: halted=%b req=%b%b required 1 00", halted, imem_req, dmem_req); end
        step(5);
        checks++;
        if ({halted, imem_req, dmem_req, pc, retire_cnt} !== {3'b100, 32'h0, 32'd0}) begin
            errors++;
            $display("FAIL halt_stay: halted=%b req=%b%b pc=%h retires=%0d required 1 00 0 0", halted, imem_req, dmem_req, pc, retire_cnt);
        end
    endtask

    task automatic test_reset_mid_fetch();
        begin_prog();
        imem[0] = addi(1, 0, 5);
        release_rst();
        step(4);
        imem_stall = 1'b1;
        step(3);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL fetch_stall: req=%b addr=%h required 1 00000004", imem_req, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, imem_req, dmem_req, retire, halted, dut.rf_q[1]} !== {32'h0, 4'b0000, 32'h0}) begin
            errors++;
            $display("FAIL mid_fetch_reset: pc=%h req=%b%b retire=%b halted=%b x1=%h required all zero", pc, imem_req, dmem_req, retire, halted, dut.rf_q[1]);
        end
        imem_stall = 1'b0;
        release_rst();
        step(4);
        checks++;
        if (pc !== 32'h4 || dut.rf_q[1] !== 32'h5) begin errors++; $display("FAIL restart: pc=%h x1=%h required 00000004 00000005", pc, dut.rf_q[1]); end
    endtask

    task automatic test_mul();
        begin_prog();
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, -3);
        imem[2] = r_t(7'h01, 2, 1, 3'b000, 6);
        release_rst();
        step(12);
        checks++;
`ifdef MC_CPU_MUL_EN
        if ({halted, pc, dut.rf_q[6]} !== {1'b0, 32'hC, 32'hFFFF_FFF1}) begin
            errors++;
            $display("FAIL mul_on: halted=%b pc=%h x6=%h required 0 0000000c fffffff1", halted, pc, dut.rf_q[6]);
        end
`else
        if ({halted, pc, dut.rf_q[6]} !== {1'b1, 32'h8, 32'h0}) begin
            errors++;
            $display("FAIL mul_off: halted=%b pc=%h x6=%h required 1 00000008 00000000", halted, pc, dut.rf_q[6]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_mem_wait();
        test_mem_zero_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_ops();
        test_halt();
        test_reset_mid_fetch();
        test_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
